// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: size encodings, FSM state type, default depth.
package mem_ctrl_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 64;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  // Encoding 11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH_WORDS x 32-bit storage: one write port, one registered read port, async clear of all words.
module mem_word_array import mem_ctrl_pkg::*; #(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [31:0]                    wr_data,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [31:0]                    rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we) mem[wr_idx] <= wr_data;
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory controller with read-modify-write for sub-word stores.
// Build option MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
// Handshake: req is sampled only in IDLE; ready pulses one cycle at completion; busy covers
// every cycle after acceptance up to and including the ready cycle.
module data_mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misaligned,
  output state_t      dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t        state, state_nx;
  logic          wr_q, mis_q, mis_in;
  logic [AW+1:0] addr_q;
  logic [1:0]    size_q, off;
  logic [31:0]   wdata_q, rd_data, merged, extracted, bit_mask, size_mask;
  logic [3:0]    lanes;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_in = ((size == SZ_HALF) && addr[0]) || (is_word(size) && (addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        wr_q    <= wr;
        mis_q   <= mis_in;
        addr_q  <= addr[AW+1:0];
        size_q  <= size;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) begin
        if (mis_in)                       state_nx = RESP;
        else if (wr && is_word(size))     state_nx = WRITE;
        else                              state_nx = READ;
      end
      READ:    state_nx = wr_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end

  // Force-aligned lane offset; trapped accesses never reach storage so they need no special case.
  always_comb begin
    off = addr_q[1:0];
    if (is_word(size_q))        off = 2'b00;
    else if (size_q == SZ_HALF) off[0] = 1'b0;
  end

  always_comb begin
    lanes     = 4'b1111;
    size_mask = 32'hFFFF_FFFF;
    if (size_q == SZ_BYTE) begin
      lanes     = 4'b0001 << off;
      size_mask = 32'h0000_00FF;
    end else if (size_q == SZ_HALF) begin
      lanes     = 4'b0011 << off;
      size_mask = 32'h0000_FFFF;
    end
  end

  assign bit_mask  = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  assign merged    = (rd_data & ~bit_mask) | ((wdata_q << {off, 3'b000}) & bit_mask);
  assign extracted = (rd_data >> {off, 3'b000}) & size_mask;

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clock   (clock),
    .reset   (reset),
    .we      (state == WRITE),
    .wr_idx  (addr_q[AW+1:2]),
    .wr_data (merged),
    .rd_idx  (addr_q[AW+1:2]),
    .rd_data (rd_data)
  );

  assign ready      = (state == RESP);
  assign busy       = (state != IDLE);
  assign misaligned = ready && mis_q;
  assign rdata      = (ready && !wr_q && !mis_q) ? extracted : 32'h0;
  assign dbg_state  = state;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: DEPTH_WORDS, default 64, number of 32-bit storage words; power of two, 16..1024.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  access request from the CPU side; sampled only in IDLE.
REQ-005 wr  input  1  1 = store, 0 = load.
REQ-006 addr  input  32  byte address; only bits [log2(DEPTH_WORDS)+1:0] are used, upper bits are ignored.
REQ-007 size  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
REQ-008 wdata  input  32  store data, right-justified for byte and half stores.
REQ-009 rdata  output  32  load result, zero-extended; valid only while ready=1.
REQ-010 ready  output  1  one-cycle pulse marking completion of an accepted request.
REQ-011 busy  output  1  high from the cycle after acceptance through the ready cycle inclusive.
REQ-012 misaligned  output  1  qualified by ready; flags a trapped misaligned access.

Function
REQ-013 Storage SHALL be DEPTH_WORDS x 32-bit words, little-endian; byte k of a word is bits [8k+7:8k].
REQ-014 The controller SHALL accept a request when req=1 in IDLE and SHALL latch wr, addr, size and wdata at that edge; later input changes SHALL be ignored.
REQ-015 req asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 FSM states SHALL be IDLE, READ, WRITE and RESP.
REQ-017 Load transitions: IDLE -> READ -> RESP -> IDLE; ready=1 in the 2nd cycle after acceptance.
REQ-018 Word store transitions: IDLE -> WRITE -> RESP -> IDLE; the array updates at the end of WRITE; ready=1 in the 2nd cycle.
REQ-019 Byte and half stores SHALL use read-modify-write: IDLE -> READ -> WRITE -> RESP -> IDLE, merging only the addressed lanes; ready=1 in the 3rd cycle.
REQ-020 Load data SHALL be word >> (8*addr[1:0]), masked to 8, 16 or 32 bits; upper bits zero.
REQ-021 rdata SHALL be 0 whenever ready=0, and 0 for stores.
REQ-022 From RESP the FSM SHALL return to IDLE unconditionally; a req held high is accepted at the first IDLE edge, giving back-to-back throughput of one access per 3 or 4 cycles.
REQ-023 Address wrap: word index = addr[log2(DEPTH_WORDS)+1:2], so out-of-range addresses alias modulo the array size.

Reset
REQ-024 Reset SHALL force IDLE, ready=0, busy=0, misaligned=0, rdata=0, and clear all storage words to 0.
REQ-025 Reset asserted mid-access SHALL abort it; no write is committed unless the WRITE edge completed before reset rose; no ready pulse follows.

Configuration
REQ-026 Macro MEM_MISALIGN_TRAP_EN. Defined: a half store or load with addr[0]=1, or a word access with addr[1:0]!=0, SHALL skip the storage access and go IDLE -> RESP, giving ready=1, misaligned=1 and rdata=0 in the 1st cycle after acceptance; storage is unchanged.
REQ-027 Not defined: the address SHALL be force-aligned (half: addr[0]=0; word: addr[1:0]=0), the access SHALL proceed normally, and misaligned SHALL be tied to 0.

Structure
REQ-028 The shared package mem_ctrl_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the DEPTH_WORDS default.
REQ-029 Storage SHALL be a sub-module mem_word_array: 1 write port and 1 read port with registered read, plus async clear.
REQ-030 Lane merge, alignment and extraction logic SHALL remain combinational inside data_mem_ctrl.

Verification
REQ-031 Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=10 -> ready at cycle 2; load addr=0x10 -> rdata=0xDEADBEEF, ready at cycle 2.
REQ-032 Byte RMW: on word 0x10 = 0xDEADBEEF, store byte addr=0x12, wdata=0x55 -> ready at cycle 3; word load -> 0xDE55BEEF; byte load at 0x13 -> 0x000000DE.
REQ-033 Half load: on word 0x10 = 0xDE55BEEF, load half at 0x12 -> 0x0000DE55.
REQ-034 Misaligned word load at addr=0x11:
  - With MEM_MISALIGN_TRAP_EN: ready=1, misaligned=1, rdata=0 at cycle 1.
  - Without it: rdata equals the word at 0x10, misaligned=0.
REQ-035 Busy and wrap:
  - req pulsed during busy -> ignored, only one ready pulse.
  - With DEPTH_WORDS=64: a store to 0x100 followed by a load from 0x000 -> returns the stored value.
REQ-036 Reset mid-op: assert reset during READ of a byte store -> no ready pulse; a later load of that word returns 0.
